// File: rtl/uart_receiver.sv
// UART receiver: synchronizes an idle-high serial line and recovers LSB-first frames
// with a per-bit clock count, glitch-filtered start bit and stop-bit error reporting.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   shift, shift_n, byte_n;
    logic                   valid_n, err_n;

    assign rx_s = sync[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync       <= '1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], bit_in};
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            byte_out   <= byte_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        byte_n  = byte_out;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt == HALF_C) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST_C) begin
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    cnt_n   = '0;
                    idx_n   = idx + 1'b1;
                    if (idx == LAST_IDX) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST_C) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        byte_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break is not read as 0x00 frames.
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized scoreboard bench for uart_receiver: a behavioural transmitter drives frames,
// expected strobes are queued with their due cycle and a monitor checks what the DUT presents.
module tb_uart_receiver;

    localparam int CPB  = 4;
    localparam int DB   = 8;
    localparam int SS   = 2;
    localparam int LAT  = SS + 1 + CPB / 2 + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          bit_in;
    logic [DB-1:0] byte_out;
    logic          byte_valid, frame_err, busy;

    typedef struct {
        logic          err;
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    logic [DB-1:0] last_good = '0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .byte_out(byte_out),
        .byte_valid(byte_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transmit one frame starting at the next posedge; queue the strobe it must produce.
    task automatic send_frame(input logic [DB-1:0] data, input logic stop, input int gap);
        exp_t e;
        logic [DB+1:0] bits;
        bits  = {stop, data, 1'b0};
        e.cyc = cyc + 1 + LAT;
        e.err = ~stop;
        if (stop) last_good = data;
        e.data = last_good;
        q.push_back(e);
        for (int b = 0; b < DB + 2; b++) begin
            bit_in = bits[b];
            for (int i = 0; i < CPB; i++) begin
                @(negedge clk);
                if (b == 0 && i == 1)       check("busy_before_start", busy, 0);
                if (b == 0 && i == CPB - 1) check("busy_in_start", busy, 1);
            end
        end
        bit_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the queue, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (byte_valid && frame_err) check("valid_and_err_together", 1, 0);
            if (byte_valid || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", {byte_valid, frame_err, byte_out}, 0);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind_err", frame_err, e.err);
                    check("byte_out", byte_out, e.data);
                    check("strobe_cycle", cyc, e.cyc);
                    if (byte_valid) check("busy_in_valid_cycle", busy, 0);
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                check("missing_strobe_at", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        bit_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_byte_out", byte_out, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);

        // Single frame
        send_frame(8'hA5, 1'b1, 6);

        // Start-bit glitch, then a good frame
        bit_in = 1'b0;
        @(negedge clk);
        bit_in = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_after_glitch", busy, 0);
        send_frame(8'h3C, 1'b1, 4);

        // Bad stop bit, line held low, then recovery
        send_frame(8'h5A, 1'b0, 0);
        bit_in = 1'b0;
        repeat (20) @(negedge clk);
        bit_in = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_break", busy, 0);
        send_frame(8'h81, 1'b1, 4);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 6);

        // Reset in the middle of data bit 4
        bit_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            bit_in = b[0];
            repeat (CPB) @(negedge clk);
        end
        bit_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_byte_out", byte_out, 0);
        check("midrst_byte_valid", byte_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_busy", busy, 0);
        reset     = 1'b1;
        last_good = '0;
        repeat (4) @(negedge clk);
        send_frame(8'hC3, 1'b1, 3);

        // Loopback stream of random bytes with random short gaps
        for (int n = 0; n < 256; n++)
            send_frame(DB'($urandom), 1'b1, int'($urandom_range(0, 5)));

        for (int t = 0; t < LAT + 20 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) check("drain_timeout_pending", q.size(), 0);
        repeat (2) @(negedge clk);
        check("final_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
